// File: rtl/jogo_desafio_memoria_top.sv
// "Genius" memory game: control FSM plus datapath (jogada RAM, address/round
// counters, timeout counter, button edge detector) with 7-segment debug taps.
module jogo_desafio_memoria_top #(
    parameter int TIMEOUT  = 5000,
    parameter int T_MOSTRA = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] botoes,
    output logic       ganhou,
    output logic       perdeu,
    output logic       pronto,
    output logic [3:0] leds,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic [6:0] db_rodada,
    output logic       db_clock,
    output logic       db_tem_jogada,
    output logic       db_timeout,
    output logic       db_jogada_correta,
    output logic       db_enderecoIgualRodada,
    output logic       db_grava,
    output logic [12:0] db_Q
);
    localparam int MW = $clog2(T_MOSTRA + 1);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        MOSTRA         = 4'h2,
        INICIA_RODADA  = 4'h3,
        ESPERA         = 4'h4,
        REGISTRA       = 4'h5,
        COMPARA        = 4'h6,
        PROXIMA        = 4'h7,
        ESPERA_NOVA    = 4'h8,
        REGISTRA_NOVA  = 4'h9,
        GRAVA          = 4'hA,
        PROXIMA_RODADA = 4'hB,
        FIM_GANHOU     = 4'hC,
        FIM_PERDEU     = 4'hD,
        FIM_TIMEOUT    = 4'hE
    } estado_t;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    estado_t        estado;
    logic [3:0]     endereco;
    logic [3:0]     rodada;
    logic [3:0]     jogada;
    logic [3:0]     mem [16];
    logic [3:0]     dado;
    logic [12:0]    conta_q;
    logic [MW-1:0]  mostra_cnt;
    logic           tem_jogada, tem_jogada_q, jogada_evento;
    logic [3:0]     botoes_cap;
    logic           timeout_flag, jogada_correta, endereco_igual, grava;

    assign dado           = mem[endereco];
    assign tem_jogada     = |botoes;
    assign timeout_flag   = conta_q >= 13'(TIMEOUT - 1);
    assign jogada_correta = jogada == dado;
    assign endereco_igual = endereco == rodada;
    assign grava          = estado == GRAVA;

    // Buttons are captured at the edge so a short press still yields its value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tem_jogada_q  <= 1'b0;
            jogada_evento <= 1'b0;
            botoes_cap    <= 4'd0;
        end else begin
            tem_jogada_q  <= tem_jogada;
            jogada_evento <= tem_jogada & ~tem_jogada_q;
            if (tem_jogada & ~tem_jogada_q)
                botoes_cap <= botoes;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            endereco   <= 4'd0;
            rodada     <= 4'd0;
            jogada     <= 4'd0;
            conta_q    <= 13'd0;
            mostra_cnt <= '0;
            for (int i = 0; i < 16; i++)
                mem[i] <= (i == 0) ? 4'b0001 : 4'b0000;
        end else begin
            mostra_cnt <= (estado == MOSTRA) ? mostra_cnt + 1'b1 : '0;
            case (estado)
                PREPARACAO: begin
                    endereco <= 4'd0;
                    rodada   <= 4'd0;
                    jogada   <= 4'd0;
                    conta_q  <= 13'd0;
                end
                INICIA_RODADA: begin
                    endereco <= 4'd0;
                    conta_q  <= 13'd0;
                end
                ESPERA, ESPERA_NOVA: begin
                    if (conta_q != 13'h1FFF)
                        conta_q <= conta_q + 13'd1;
                end
                REGISTRA, REGISTRA_NOVA: begin
                    jogada  <= botoes_cap;
                    conta_q <= 13'd0;
                end
                PROXIMA: begin
                    endereco <= endereco + 4'd1;
                    conta_q  <= 13'd0;
                end
                PROXIMA_RODADA: begin
                    if (rodada != 4'hF)
                        rodada <= rodada + 4'd1;
                end
                default: ;
            endcase
            if (grava)
                mem[rodada + 4'd1] <= jogada;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
            ganhou <= 1'b0;
            perdeu <= 1'b0;
            pronto <= 1'b0;
        end else begin
            case (estado)
                INICIAL:       if (iniciar) estado <= PREPARACAO;
                PREPARACAO:    estado <= MOSTRA;
                MOSTRA:        if (mostra_cnt == MW'(T_MOSTRA - 1)) estado <= INICIA_RODADA;
                INICIA_RODADA: estado <= ESPERA;
                ESPERA, ESPERA_NOVA: begin
                    // Timeout has priority over a jogada arriving in the same cycle.
                    if (timeout_flag) begin
                        estado <= FIM_TIMEOUT;
                        perdeu <= 1'b1;
                        pronto <= 1'b1;
                    end else if (jogada_evento) begin
                        estado <= (estado == ESPERA) ? REGISTRA : REGISTRA_NOVA;
                    end
                end
                REGISTRA:      estado <= COMPARA;
                COMPARA: begin
                    if (!jogada_correta) begin
                        estado <= FIM_PERDEU;
                        perdeu <= 1'b1;
                        pronto <= 1'b1;
                    end else if (!endereco_igual) begin
                        estado <= PROXIMA;
                    end else if (rodada == 4'hF) begin
                        estado <= PROXIMA_RODADA;
                    end else begin
                        estado <= ESPERA_NOVA;
                    end
                end
                PROXIMA:       estado <= ESPERA;
                REGISTRA_NOVA: estado <= GRAVA;
                GRAVA:         estado <= PROXIMA_RODADA;
                PROXIMA_RODADA: begin
                    if (rodada == 4'hF) begin
                        estado <= FIM_GANHOU;
                        ganhou <= 1'b1;
                        pronto <= 1'b1;
                    end else begin
                        estado <= INICIA_RODADA;
                    end
                end
                FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
                    if (iniciar) begin
                        estado <= PREPARACAO;
                        ganhou <= 1'b0;
                        perdeu <= 1'b0;
                        pronto <= 1'b0;
                    end
                end
                default:       estado <= INICIAL;
            endcase
        end
    end

    assign leds                   = (estado == MOSTRA) ? dado : botoes;
    assign db_contagem            = hex7(endereco);
    assign db_memoria             = hex7(dado);
    assign db_estado              = hex7(estado);
    assign db_jogadafeita         = hex7(jogada);
    assign db_rodada              = hex7(rodada);
    assign db_clock               = clock;
    assign db_tem_jogada          = tem_jogada;
    assign db_timeout             = timeout_flag;
    assign db_jogada_correta      = jogada_correta;
    assign db_enderecoIgualRodada = endereco_igual;
    assign db_grava               = grava;
    assign db_Q                   = conta_q;
endmodule

// File: tb/tb_jogo_desafio_memoria_top.sv
// Directed bench for the memory game: reset, show phase, full win, wrong
// jogada, timeout, restart and mid-round reset.
module tb_jogo_desafio_memoria_top;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] botoes = 4'd0;
    logic       ganhou, perdeu, pronto;
    logic [3:0] leds;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_rodada;
    logic       db_clock, db_tem_jogada, db_timeout, db_jogada_correta;
    logic       db_enderecoIgualRodada, db_grava;
    logic [12:0] db_Q;

    jogo_desafio_memoria_top dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
        .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .leds(leds),
        .db_contagem(db_contagem), .db_memoria(db_memoria), .db_estado(db_estado),
        .db_jogadafeita(db_jogadafeita), .db_rodada(db_rodada), .db_clock(db_clock),
        .db_tem_jogada(db_tem_jogada), .db_timeout(db_timeout),
        .db_jogada_correta(db_jogada_correta),
        .db_enderecoIgualRodada(db_enderecoIgualRodada), .db_grava(db_grava),
        .db_Q(db_Q)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: seg = 7'h40; 4'h1: seg = 7'h79; 4'h2: seg = 7'h24; 4'h3: seg = 7'h30;
            4'h4: seg = 7'h19; 4'h5: seg = 7'h12; 4'h6: seg = 7'h02; 4'h7: seg = 7'h78;
            4'h8: seg = 7'h00; 4'h9: seg = 7'h10; 4'hA: seg = 7'h08; 4'hB: seg = 7'h03;
            4'hC: seg = 7'h46; 4'hD: seg = 7'h21; 4'hE: seg = 7'h06; default: seg = 7'h0E;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic [3:0] b);
        botoes = b;
        tick(100);
        botoes = 4'd0;
        tick(100);
    endtask

    task automatic wait_state(input logic [3:0] code, input int budget, input string name);
        int k = 0;
        while (db_estado !== seg(code) && k < budget) begin
            tick(1);
            k++;
        end
        check(name, {25'd0, db_estado}, {25'd0, seg(code)});
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
    endtask

    typedef struct {
        logic [3:0] b;
        logic [3:0] st;
        logic       g, p, pr;
    } vec_t;

    vec_t       tab [8];
    logic [3:0] seq [16];
    logic [3:0] exp_q [$];

    initial begin
        int   n2;
        logic leds_ok;
        logic [3:0] b;

        // wrong jogada in round 2: expects 0100, gets 1000
        tab[0] = '{4'h1, 4'h8, 1'b0, 1'b0, 1'b0};
        tab[1] = '{4'h2, 4'h4, 1'b0, 1'b0, 1'b0};
        tab[2] = '{4'h1, 4'h4, 1'b0, 1'b0, 1'b0};
        tab[3] = '{4'h2, 4'h8, 1'b0, 1'b0, 1'b0};
        tab[4] = '{4'h4, 4'h4, 1'b0, 1'b0, 1'b0};
        tab[5] = '{4'h1, 4'h4, 1'b0, 1'b0, 1'b0};
        tab[6] = '{4'h2, 4'h4, 1'b0, 1'b0, 1'b0};
        tab[7] = '{4'h8, 4'hD, 1'b0, 1'b1, 1'b1};
        seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2,
                4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8};
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i <= r; i++) exp_q.push_back(seq[i]);
            if (r < 15) exp_q.push_back(seq[r + 1]);
        end

        // reset state
        tick(1);
        check("rst_estado", {25'd0, db_estado}, {25'd0, seg(4'h0)});
        check("rst_ganhou", {31'd0, ganhou}, 32'd0);
        check("rst_perdeu", {31'd0, perdeu}, 32'd0);
        check("rst_pronto", {31'd0, pronto}, 32'd0);
        check("rst_grava", {31'd0, db_grava}, 32'd0);
        check("rst_timeout", {31'd0, db_timeout}, 32'd0);
        check("rst_q", {19'd0, db_Q}, 32'd0);
        check("rst_mem0", {25'd0, db_memoria}, {25'd0, seg(4'h1)});
        check("rst_rodada", {25'd0, db_rodada}, {25'd0, seg(4'h0)});
        reset = 1'b1;
        tick(1);

        // show phase: iniciar held 5 cycles, leds = 0001 for T_MOSTRA cycles
        iniciar = 1'b1;
        n2 = 0;
        leds_ok = 1'b1;
        for (int k = 0; k < 1100; k++) begin
            tick(1);
            if (k == 4) iniciar = 1'b0;
            if (db_estado === seg(4'h2)) begin
                n2++;
                if (leds !== 4'b0001) leds_ok = 1'b0;
            end else if (n2 > 0) begin
                break;
            end
        end
        check("mostra_len", n2, 1000);
        check("mostra_leds", {31'd0, leds_ok}, 32'd1);
        check("after_mostra", {25'd0, db_estado}, {25'd0, seg(4'h3)});
        wait_state(4'h4, 10, "first_espera");

        botoes = 4'b0100;
        #1;
        check("tem_jogada", {31'd0, db_tem_jogada}, 32'd1);
        check("leds_follow", {28'd0, leds}, 32'h4);
        botoes = 4'd0;
        tick(1);

        // winning run, jogadas come from the expected queue
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i <= r; i++) begin
                b = exp_q.pop_front();
                press(b);
                check($sformatf("win_jog_r%0d_i%0d", r, i), {25'd0, db_jogadafeita}, {25'd0, seg(b)});
                check($sformatf("win_st_r%0d_i%0d", r, i), {25'd0, db_estado},
                      {25'd0, seg((i < r) ? 4'h4 : ((r == 15) ? 4'hC : 4'h8))});
            end
            if (r < 15) begin
                b = exp_q.pop_front();
                press(b);
                check($sformatf("win_new_r%0d", r), {25'd0, db_estado}, {25'd0, seg(4'h4)});
            end
        end
        check("win_ganhou", {31'd0, ganhou}, 32'd1);
        check("win_pronto", {31'd0, pronto}, 32'd1);
        check("win_perdeu", {31'd0, perdeu}, 32'd0);
        check("win_rodada", {25'd0, db_rodada}, {25'd0, seg(4'hF)});
        check("win_contagem", {25'd0, db_contagem}, {25'd0, seg(4'hF)});
        check("win_mem15", {25'd0, db_memoria}, {25'd0, seg(4'h8)});
        check("win_igual", {31'd0, db_enderecoIgualRodada}, 32'd1);

        press(4'h1);
        check("extra_estado", {25'd0, db_estado}, {25'd0, seg(4'hC)});
        check("extra_ganhou", {31'd0, ganhou}, 32'd1);
        check("extra_pronto", {31'd0, pronto}, 32'd1);

        // restart from C
        start_game();
        check("restart_estado", {25'd0, db_estado}, {25'd0, seg(4'h1)});
        check("restart_ganhou", {31'd0, ganhou}, 32'd0);
        check("restart_pronto", {31'd0, pronto}, 32'd0);
        wait_state(4'h4, 1100, "restart_espera");
        check("restart_rodada", {25'd0, db_rodada}, {25'd0, seg(4'h0)});

        for (int v = 0; v < 8; v++) begin
            press(tab[v].b);
            check($sformatf("tab%0d_estado", v), {25'd0, db_estado}, {25'd0, seg(tab[v].st)});
            check($sformatf("tab%0d_ganhou", v), {31'd0, ganhou}, {31'd0, tab[v].g});
            check($sformatf("tab%0d_perdeu", v), {31'd0, perdeu}, {31'd0, tab[v].p});
            check($sformatf("tab%0d_pronto", v), {31'd0, pronto}, {31'd0, tab[v].pr});
        end
        check("lose_rodada", {25'd0, db_rodada}, {25'd0, seg(4'h2)});
        check("lose_contagem", {25'd0, db_contagem}, {25'd0, seg(4'h2)});
        check("lose_mem", {25'd0, db_memoria}, {25'd0, seg(4'h4)});
        check("lose_jogada", {25'd0, db_jogadafeita}, {25'd0, seg(4'h8)});
        check("lose_correta", {31'd0, db_jogada_correta}, 32'd0);

        // timeout: 5000 cycles idle in state 4
        start_game();
        wait_state(4'h4, 1100, "to_espera");
        tick(4998);
        check("to_before", {31'd0, db_timeout}, 32'd0);
        tick(1);
        check("to_flag", {31'd0, db_timeout}, 32'd1);
        check("to_q", {19'd0, db_Q}, 32'd4999);
        check("to_still4", {25'd0, db_estado}, {25'd0, seg(4'h4)});
        tick(1);
        check("to_estado", {25'd0, db_estado}, {25'd0, seg(4'hE)});
        check("to_perdeu", {31'd0, perdeu}, 32'd1);
        check("to_pronto", {31'd0, pronto}, 32'd1);
        check("to_ganhou", {31'd0, ganhou}, 32'd0);

        // asynchronous reset in the middle of a round
        start_game();
        wait_state(4'h4, 1100, "mid_espera");
        press(4'h1);
        check("mid_estado8", {25'd0, db_estado}, {25'd0, seg(4'h8)});
        reset = 1'b0;
        #1;
        check("async_estado", {25'd0, db_estado}, {25'd0, seg(4'h0)});
        check("async_pronto", {31'd0, pronto}, 32'd0);
        check("async_q", {19'd0, db_Q}, 32'd0);
        check("async_mem0", {25'd0, db_memoria}, {25'd0, seg(4'h1)});
        tick(1);
        reset = 1'b1;
        tick(2);
        check("post_rst_idle", {25'd0, db_estado}, {25'd0, seg(4'h0)});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jogo_desafio_memoria_top.md
# jogo_desafio_memoria_top

Top-level "Genius" memory-challenge game (module name `jogo_desafio_memoria_top`). A control FSM and a datapath hold a 16×4 jogada RAM, address and round counters, a timeout counter and an edge detector. Each round, the player repeats the stored sequence and then appends one new jogada, which is written to RAM. The game ends with a win, a wrong jogada or a timeout, and exposes 7-segment and single-bit debug outputs for board bring-up.

## Interface
- `TIMEOUT`, 5000: cycles allowed between jogadas before loss.
- `T_MOSTRA`, 1000: cycles the first jogada is shown on `leds`.
- `clock` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `iniciar` in 1: start/restart request, level-sensitive.
- `botoes` in 4: player buttons, one-hot when pressed.
- `ganhou` out 1: game won.
- `perdeu` out 1: game lost (wrong jogada or timeout).
- `pronto` out 1: game finished.
- `leds` out 4: jogada display.
- `db_contagem` out 7: 7-seg of the address counter.
- `db_memoria` out 7: 7-seg of the RAM data at the current address.
- `db_estado` out 7: 7-seg of the FSM state code.
- `db_jogadafeita` out 7: 7-seg of the jogada register.
- `db_rodada` out 7: 7-seg of the round counter.
- `db_clock` out 1: equals `clock`.
- `db_tem_jogada` out 1: `|botoes`.
- `db_timeout` out 1: timeout flag.
- `db_jogada_correta` out 1: jogada register equals RAM data.
- `db_enderecoIgualRodada` out 1: address equals round.
- `db_grava` out 1: RAM write enable.
- `db_Q` out 13: timeout counter value.

## Operation
- 7-seg encoding: hex digit, segments gfedcba, active-low. State code 0x0–0xE is shown as a hex digit.
- RAM: 16×4, combinational read, synchronous write at address `rodada+1`.
  - Reset loads address 0 with 0001 and all other addresses with 0000.
  - Data is written from the jogada register.
- Jogada detection: a rising edge of `|botoes`, registered one cycle, loads the jogada register with `botoes`. Holding a button produces only one jogada.
- FSM states (code):
  - 0 inicial: wait for `iniciar`.
  - 1 preparacao: clear address, round, timeout counter and jogada register.
  - 2 mostra: `leds` = mem[0] for `T_MOSTRA` cycles.
  - 3 inicia_rodada: address ← 0, timeout cleared.
  - 4 espera: wait for a jogada.
  - 5 registra: load the jogada register.
  - 6 compara: wrong → D. Correct and address≠rodada → 7. Correct and address=rodada → B if rodada=15, else 8.
  - 7 proxima: address+1, timeout cleared, → 4.
  - 8 espera_nova: wait for the new jogada.
  - 9 registra_nova: load the jogada register.
  - A grava: write mem[rodada+1], `db_grava`=1.
  - B: rodada=15 → C. Otherwise rodada+1 → 3.
  - C fim_ganhou, D fim_perdeu, E fim_timeout.
- Timeout in state 4 or 8 → E.
- Outputs: `pronto`=1 in C/D/E. `ganhou`=1 in C. `perdeu`=1 in D/E.
- In C/D/E, `iniciar` → 1 (new game; the RAM keeps its contents). Jogadas made in C/D/E are ignored.
- `leds` = mem[address] in state 2, otherwise `botoes`.
- Counters: address and rodada are 4 bits. Rodada never wraps, because C is entered at 15.

## Timing
- Reset (asynchronous):
  - State → 0; all counters and registers → 0; RAM address 0 → 0001.
  - `ganhou`/`perdeu`/`pronto`/`db_grava`/`db_timeout` = 0; `leds` = `botoes`.
  - Resetting mid-game aborts immediately.
- `iniciar` is sampled in state 0 or C/D/E; a multi-cycle high starts only one game.
- A jogada edge is acted on within 3 cycles: detect → registra → compara.
- Timeout counter:
  - Counts each cycle in states 4/8, saturating at 8191.
  - `db_timeout`=1 when count ≥ `TIMEOUT`−1; the FSM enters E on the next edge.
  - Cleared on every accepted jogada and in states 1/3/7.
- A button press arriving simultaneously with timeout: the timeout wins.
- The win/lose outputs assert on the clock edge entering C/D/E and hold until restart or reset.

## Test plan
- Reset low 1 cycle → state 0, all flags 0, `db_estado` shows 0.
- `iniciar`=1 for 5 cycles → state 2; `leds`=0001 for 1000 cycles, then state 4.
- Winning run (100-cycle presses, 100-cycle gaps):
  - Round 0: 0001, then new jogada 0010.
  - Round r: repeat mem[0..r], then add mem[r+1].
  - Sequence 1,2,4,8,4,2,1,2,4,8,4,2,1,2,4,8.
  - Round 15 repeats all 16 entries → `ganhou`=1, `pronto`=1; an extra press leaves outputs unchanged.
- Wrong jogada in round 2 (0100 expected, 1000 pressed) → `perdeu`=1, `pronto`=1, state D.
- No press for 5000 cycles in state 4 → `db_timeout`=1, state E, `perdeu`=1.
- `iniciar` in state C → new game; reset low mid-round → state 0 instantly.
